// File: rtl/dlx_mem_responder.sv
// Memory-side responder for the DLX control FSM's MR/MW/busy handshake.
// Word-addressed internal RAM, one access at a time, fixed read/write wait states.
module dlx_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  state_t              state_r, state_nxt_s;
  logic [3:0]          cnt_r, cnt_nxt_s;
  logic                op_rd_r, op_rd_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic [DATA_W-1:0]   din_r, din_nxt_s;
  logic                err_set_s;
  logic                go_ack_s;
  logic                acc_rd_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [DATA_W-1:0]   mem_wdata_s;
  logic [DATA_W-1:0]   mem_r [0:(1<<ADDR_W)-1];

  // Next-state, busy and RAM access decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    op_rd_nxt_s = op_rd_r;
    addr_nxt_s  = addr_r;
    din_nxt_s   = din_r;
    busy        = 1'b0;
    err_set_s   = 1'b0;
    go_ack_s    = 1'b0;
    acc_rd_s    = op_rd_r;
    mem_addr_s  = addr_r;
    mem_wdata_s = din_r;
    case (state_r)
      ST_IDLE: begin
        if (MR ^ MW) begin
          busy        = 1'b1;
          op_rd_nxt_s = MR;
          addr_nxt_s  = ADDR;
          din_nxt_s   = DIN;
          cnt_nxt_s   = MR ? RD_CNT : WR_CNT;
          if (cnt_nxt_s == 4'd0) begin
            // Zero-wait access completes on this edge, straight from the ports.
            state_nxt_s = ST_ACK;
            go_ack_s    = 1'b1;
            acc_rd_s    = MR;
            mem_addr_s  = ADDR;
            mem_wdata_s = DIN;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end else if (MR && MW) begin
          err_set_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (!(op_rd_r ? MR : MW)) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_nxt_s = ST_ACK;
          cnt_nxt_s   = 4'd0;
          go_ack_s    = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_ACK: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // Control state, latched request, read data and sticky error.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      op_rd_r <= 1'b0;
      addr_r  <= '0;
      din_r   <= '0;
      DOUT    <= '0;
      err     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      op_rd_r <= op_rd_nxt_s;
      addr_r  <= addr_nxt_s;
      din_r   <= din_nxt_s;
      if (go_ack_s && acc_rd_s) begin
        DOUT <= mem_r[mem_addr_s];
      end
      if (err_set_s) begin
        err <= 1'b1;
      end
    end
  end

  // RAM contents survive reset; a write caught by reset is dropped.
  always_ff @(posedge CLK) begin
    if (RESET_N && go_ack_s && !acc_rd_s) begin
      mem_r[mem_addr_s] <= mem_wdata_s;
    end
  end

endmodule
